// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready,
// MSB-first bits out. Optional parity bit via SER_PARITY_EN.
module seq_bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             bit_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             last_bit,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t                 state_q, state_d;
  // Holds the bits still queued behind the one on dout.
  logic [FRAME_LEN-2:0]   shreg_q, shreg_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic [FRAME_LEN-1:0]   frame;
  logic                   advance;
  logic                   accept;

`ifdef SER_PARITY_EN
  assign frame = {load_data, ^load_data};
`else
  assign frame = load_data;
`endif

  // State and datapath registers; reset discards any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dout_q  <= IDLE_LEVEL;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // Handshake, shift and end-of-frame decisions.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    valid_d    = valid_q;
    last_d     = last_q;
    load_ready = 1'b0;
    advance    = valid_q && bit_en;

    unique case (state_q)
      S_IDLE:  load_ready = 1'b1;
      S_SHIFT: load_ready = last_q && bit_en;
      default: load_ready = 1'b0;
    endcase

    accept = load_valid && load_ready;

    if (accept) begin
      state_d = S_SHIFT;
      shreg_d = frame[FRAME_LEN-2:0];
      cnt_d   = '0;
      dout_d  = frame[FRAME_LEN-1];
      valid_d = 1'b1;
      last_d  = 1'b0;
    end else if (advance && last_q) begin
      state_d = S_IDLE;
      shreg_d = '0;
      cnt_d   = '0;
      dout_d  = IDLE_LEVEL;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (advance) begin
      shreg_d = shreg_q << 1;
      cnt_d   = cnt_q + 1'b1;
      dout_d  = shreg_q[FRAME_LEN-2];
      last_d  = (cnt_d == LAST_CNT);
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign last_bit   = last_q;
  assign busy       = valid_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: directed steps plus random
// traffic checked against a bit-queue reference model.
module tb_seq_bit_serializer;

  localparam int   W  = 8;
  localparam logic IL = 1'b0;
`ifdef SER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk;
  logic         rst_n;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         bit_en;
  logic         dout;
  logic         dout_valid;
  logic         last_bit;
  logic         busy;

  seq_bit_serializer #(
    .WIDTH(W),
    .IDLE_LEVEL(IL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .bit_en(bit_en),
    .dout(dout),
    .dout_valid(dout_valid),
    .last_bit(last_bit),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit          q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] cap;
  int          ncap;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) q.push_back(d[i]);
`ifdef SER_PARITY_EN
    q.push_back(^d);
`endif
  endtask

  task automatic step(input logic lv,
                      input logic [W-1:0] ld,
                      input logic be);
    logic ev, ed, el, er;
    bit   acc;
    @(negedge clk);
    load_valid = lv;
    load_data  = ld;
    bit_en     = be;
    #1;
    ev = (q.size() > 0);
    ed = IL;
    if (ev) ed = q[0];
    el = (q.size() == 1);
    er = (q.size() == 0) || ((q.size() == 1) && be);
    chk("dout_valid", 64'(dout_valid), 64'(ev));
    chk("dout", 64'(dout), 64'(ed));
    chk("last_bit", 64'(last_bit), 64'(el));
    chk("busy", 64'(busy), 64'(ev));
    chk("load_ready", 64'(load_ready), 64'(er));
    if (dout_valid === 1'b1 && be) begin
      cap = {cap[62:0], dout};
      ncap++;
    end
    acc = lv && er;
    @(posedge clk);
    if (rst_n) begin
      if (ev && be) void'(q.pop_front());
      if (acc) push_frame(ld);
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
  endtask

  logic [63:0] exp_frame;

  function automatic logic [63:0] frame_of(input logic [W-1:0] d);
`ifdef SER_PARITY_EN
    return 64'({d, ^d});
`else
    return 64'(d);
`endif
  endfunction

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    bit_en     = 1'b0;
    cap        = '0;
    ncap       = 0;

    // Reset state, including a handshake attempt held in reset.
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 8'hFF;
    @(negedge clk);
    #1;
    chk("rst_dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'(IL));
    chk("rst_last_bit", 64'(last_bit), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_load_ready", 64'(load_ready), 64'd1);
    load_valid = 1'b0;
    rst_n      = 1'b1;

    // Single word, no stall.
    ncap = 0;
    step(1'b1, 8'h0B, 1'b1);
    idle_steps(FL + 2);
    chk("t1_nbits", 64'(ncap), 64'(FL));
    chk("t1_bits", cap & ((64'd1 << FL) - 1), frame_of(8'h0B));

    // Back-to-back words with load_valid held high.
    ncap = 0;
    step(1'b1, 8'hB0, 1'b1);
    for (int i = 0; i < FL; i++) step(1'b1, 8'h0B, 1'b1);
    idle_steps(FL + 2);
    exp_frame = (frame_of(8'hB0) << FL) | frame_of(8'h0B);
    chk("t2_nbits", 64'(ncap), 64'(2 * FL));
    chk("t2_bits", cap & ((64'd1 << (2 * FL)) - 1), exp_frame);

    // Stall for three cycles after the second bit.
    ncap = 0;
    step(1'b1, 8'hA5, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    idle_steps(FL + 1);
    chk("t3_nbits", 64'(ncap), 64'(FL));
    chk("t3_bits", cap & ((64'd1 << FL) - 1), frame_of(8'hA5));

    // Busy rejection: 8'hFF offered mid-frame, taken on the last bit.
    ncap = 0;
    step(1'b1, 8'h33, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < FL - 3; i++) step(1'b1, 8'hFF, 1'b1);
    idle_steps(FL + 2);
    exp_frame = (frame_of(8'h33) << FL) | frame_of(8'hFF);
    chk("t4_nbits", 64'(ncap), 64'(2 * FL));
    chk("t4_bits", cap & ((64'd1 << (2 * FL)) - 1), exp_frame);

    // Asynchronous reset mid-frame.
    step(1'b1, 8'hFF, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_dout_valid", 64'(dout_valid), 64'd0);
    chk("t5_dout", 64'(dout), 64'(IL));
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_load_ready", 64'(load_ready), 64'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ncap = 0;
    step(1'b1, 8'h0B, 1'b1);
    idle_steps(FL + 2);
    chk("t5_nbits", 64'(ncap), 64'(FL));
    chk("t5_bits", cap & ((64'd1 << FL) - 1), frame_of(8'h0B));

    // Parity-sensitive word (even parity 0 when enabled).
    ncap = 0;
    step(1'b1, 8'h03, 1'b1);
    idle_steps(FL + 2);
    chk("t6_bits", cap & ((64'd1 << FL) - 1), frame_of(8'h03));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), W'($urandom),
           1'($urandom_range(0, 3) != 0));
    end
    idle_steps(3 * FL);
    chk("final_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
